n_clic_vec: RTL

Parametrised successor of the single-level CLIC: `VecSize` interrupt entries, each with a vector CSR and a config CSR (pend/enable/prio), a priority-nested preemption stack and optional external interrupt lines. Sits beside the core's CSR unit. It raises a one-cycle `irq_take` with the ISR address and the new `level_out`. That level selects the register-file bank and is restored on `mret`.

---
 rtl/n_clic_vec.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/n_clic_vec.sv
// n_clic_vec: vectored interrupt controller with priority-nested preemption.
// Each of VecSize entries has a vector CSR (30-bit ISR word address) and a
// config CSR {prio, enable, pend}. A take pushes the current level onto a
// LIFO stack and raises the level to the winner's priority. mret pops the
// stack to restore the previous level.
// Optional feature: define CLIC_EXT_IRQ_EN so that rising edges on ext_irq
// (through a 2-flop synchroniser plus an edge register) set pend.

module n_clic_vec #(
    parameter int           VecSize   = 8,
    parameter int           PrioWidth = 3,
    parameter logic [11:0]  VecBase   = 12'hB00,
    parameter logic [11:0]  EntryBase = 12'hB20,
    localparam int          IdWidth   = (VecSize > 1) ? $clog2(VecSize) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_enable,
    input  logic [11:0]          csr_addr,
    input  logic [1:0]           csr_op,
    input  logic [31:0]          rs1_data,
    output logic [31:0]          csr_rdata,
    input  logic [VecSize-1:0]   ext_irq,
    input  logic                 mret,
    output logic                 irq_take,
    output logic [31:0]          irq_addr,
    output logic [IdWidth-1:0]   irq_id,
    output logic [PrioWidth-1:0] level_out
);

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int                   StackDepth = 1 << PrioWidth;
    localparam int                   CfgWidth   = PrioWidth + 2;
    localparam logic [PrioWidth-1:0] SpOne      = PrioWidth'(1);

    // Architectural CSR state
    logic [29:0]          vec_q  [VecSize];
    logic [PrioWidth-1:0] prio_q [VecSize];
    logic [VecSize-1:0]   pend_q;
    logic [VecSize-1:0]   en_q;

    // Level stack; strictly increasing nesting means it can never overflow
    logic [PrioWidth-1:0] stack_q [StackDepth];
    logic [PrioWidth-1:0] sp_q;

    // CSR decode and write data
    logic [11:0]        vec_off;
    logic [11:0]        cfg_off;
    logic               csr_wr;
    logic [VecSize-1:0] vec_hit;
    logic [VecSize-1:0] cfg_hit;
    logic [31:0]        csr_wdata;

    // Arbitration result
    logic                 cand_found;
    logic [PrioWidth-1:0] cand_prio;
    logic [IdWidth-1:0]   cand_id;
    logic [29:0]          cand_vec;
    logic [VecSize-1:0]   cand_onehot;

    logic               pop;
    logic               take;
    logic [VecSize-1:0] ext_edge;

    assign vec_off = csr_addr - VecBase;
    assign cfg_off = csr_addr - EntryBase;
    assign csr_wr  = csr_enable && (csr_op_e'(csr_op) != OP_NONE);

    // Read mux and per-entry write strobes; reads always show the pre-write value
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that do not assign it infer a latch.
        csr_rdata = '0;
        vec_hit   = '0;
        cfg_hit   = '0;
        for (int i = 0; i < VecSize; i++) begin
            if (vec_off == 12'(i)) begin
                csr_rdata  = {2'b00, vec_q[i]};
                vec_hit[i] = csr_wr;
            end
            if (cfg_off == 12'(i)) begin
                csr_rdata  = 32'({prio_q[i], en_q[i], pend_q[i]});
                cfg_hit[i] = csr_wr;
            end
        end
    end

    // Read-modify-write value for the addressed CSR
    always_comb begin
        case (csr_op_e'(csr_op))
            OP_WRITE: csr_wdata = rs1_data;
            OP_SET:   csr_wdata = csr_rdata | rs1_data;
            OP_CLEAR: csr_wdata = csr_rdata & ~rs1_data;
            default:  csr_wdata = csr_rdata;
        endcase
    end

    // Upper write-data bits have no storage behind them
    logic [1:0] unused_wdata;
    assign unused_wdata = csr_wdata[31:30];

    // Pick the highest priority pending+enabled entry above the current level;
    // the strict compare keeps the lowest index on a tie
    always_comb begin
        cand_found  = 1'b0;
        cand_prio   = '0;
        cand_id     = '0;
        cand_vec    = '0;
        cand_onehot = '0;
        for (int i = 0; i < VecSize; i++) begin
            if (pend_q[i] && en_q[i] && (prio_q[i] > level_out) &&
                (!cand_found || (prio_q[i] > cand_prio))) begin
                cand_found  = 1'b1;
                cand_prio   = prio_q[i];
                cand_id     = IdWidth'(i);
                cand_vec    = vec_q[i];
                cand_onehot = '0;
                cand_onehot[i] = 1'b1;
            end
        end
    end

    // mret wins over a take; the cycle after a take is a blackout for the core redirect
    assign pop  = mret && (sp_q != '0);
    assign take = cand_found && !irq_take && !pop;

`ifdef CLIC_EXT_IRQ_EN
    logic [VecSize-1:0] ext_meta_q;
    logic [VecSize-1:0] ext_sync_q;
    logic [VecSize-1:0] ext_prev_q;

    // Two-flop synchroniser followed by an edge-detect register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_meta_q <= '0;
            ext_sync_q <= '0;
            ext_prev_q <= '0;
        end else begin
            ext_meta_q <= ext_irq;
            ext_sync_q <= ext_meta_q;
            ext_prev_q <= ext_sync_q;
        end
    end

    assign ext_edge = ext_sync_q & ~ext_prev_q;
`else
    logic unused_ext;
    assign unused_ext = ^ext_irq;
    assign ext_edge   = '0;
`endif

    // CSR registers; later assignments win: external edge > CSR access > take clear
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            for (int i = 0; i < VecSize; i++) begin
                vec_q[i]  <= '0;
                prio_q[i] <= '0;
            end
            pend_q <= '0;
            en_q   <= '0;
        end else begin
            for (int i = 0; i < VecSize; i++) begin
                if (take && cand_onehot[i]) begin
                    pend_q[i] <= 1'b0;
                end
                if (vec_hit[i]) begin
                    vec_q[i] <= csr_wdata[29:0];
                end
                if (cfg_hit[i]) begin
                    pend_q[i] <= csr_wdata[0];
                    en_q[i]   <= csr_wdata[1];
                    prio_q[i] <= csr_wdata[CfgWidth-1:2];
                end
                if (ext_edge[i]) begin
                    pend_q[i] <= 1'b1;
                end
            end
        end
    end

    // Take pulse, ISR target, execution level and stack pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_take  <= 1'b0;
            irq_addr  <= '0;
            irq_id    <= '0;
            level_out <= '0;
            sp_q      <= '0;
        end else begin
            irq_take <= take;
            if (take) begin
                irq_id   <= cand_id;
                irq_addr <= {cand_vec, 2'b00};
            end
            if (pop) begin
                level_out <= stack_q[sp_q - SpOne];
                sp_q      <= sp_q - SpOne;
            end else if (take) begin
                level_out <= cand_prio;
                sp_q      <= sp_q + SpOne;
            end
        end
    end

    // Stack storage written on each take
    always_ff @(posedge clk) begin
        // NOTE: the stack array is not reset; sp_q is, so stale entries are
        // never read before being pushed again.
        if (take) begin
            stack_q[sp_q] <= level_out;
        end
    end

endmodule
